// File: rtl/fetch_prefetch_unit_if.sv
// Bus bundle between the fetch/prefetch unit and its neighbours:
// instruction memory port, EX redirect input and the ID handshake.
interface fetch_prefetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               id_valid;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc;
  logic               id_ready;
  logic [CNT_W-1:0]   fifo_count;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc,
    input  id_ready,
    output fifo_count
  );

  // Memory / EX / ID side
  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc,
    output id_ready,
    input  fifo_count
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues fixed one-cycle-latency fetches,
// buffers {instr, pc} pairs in a small FIFO and hands them to decode.
// A redirect flushes the FIFO and any in-flight fetch.
module fetch_prefetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 INSTR_W  = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_unit_if.master bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INSTR_W + ADDR_W;

  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic               inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               has_space;
  logic               push;
  logic               pop;
  logic               req;
  logic [ENTRY_W-1:0] head;

  // Space accounts for the in-flight response so a push can never overflow.
  // id_ready is deliberately absent here: no combinational ready-to-request path.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign has_space = occupancy < (CNT_W+1)'(DEPTH);
  assign req       = reset && !bus.redirect_valid && has_space;
  assign push      = inflight_q && !bus.redirect_valid;
  assign pop       = (count_q != '0) && bus.id_ready && !bus.redirect_valid;
  assign head      = mem_q[rd_ptr_q];

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.id_valid   = (count_q != '0);
  assign bus.id_instr   = head[ENTRY_W-1:ADDR_W];
  assign bus.id_pc      = head[ADDR_W-1:0];
  assign bus.fifo_count = count_q;

  // Next-state for fetch PC, in-flight tracking and FIFO pointers/count
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (req) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage write: capture the returning instruction with its PC
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q] = {bus.imem_rdata, inflight_pc_q};
  end

  // State registers; storage is cleared too so ID outputs read 0 in reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit. Instruction memory model returns
// mem[a] = a + 0x1000 one cycle after each accepted request.
module tb_fetch_prefetch_unit;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  logic [15:0] exp_pc;
  logic [15:0] exp_instr;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: sample request mid-cycle, answer just after the edge
  initial begin : imem_model
    logic        r;
    logic [15:0] a;
    bus.imem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      r = bus.imem_req;
      a = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rdata = r ? (a + 16'h1000) : 16'hDEAD;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : stim
    n_assert = 0;
    n_fail   = 0;
    reset              = 1'b0;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    repeat (2) tick();

    // Reset state
    chk("rst_req",   bus.imem_req,   0);
    chk("rst_valid", bus.id_valid,   0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_pc",    bus.id_pc,      0);
    chk("rst_instr", bus.id_instr,   0);

    // Streaming with id_ready=1
    reset = 1'b1;
    #1;
    chk("first_req",  bus.imem_req,  1);
    chk("first_addr", bus.imem_addr, 0);
    chk("first_valid", bus.id_valid, 0);
    tick();
    chk("e1_valid", bus.id_valid,  0);
    chk("e1_addr",  bus.imem_addr, 1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", bus.id_valid,   1);
      chk("stream_pc",    bus.id_pc,      i);
      chk("stream_instr", bus.id_instr,   32'h1000 + i);
      chk("stream_count", bus.fifo_count, 1);
      tick();
    end

    // Mid-stream asynchronous reset with two entries buffered
    bus.id_ready = 1'b0;
    tick();
    chk("pre_rst_count", bus.fifo_count, 2);
    chk("pre_rst_pc",    bus.id_pc,      6);
    reset = 1'b0;
    #1;
    chk("async_req",   bus.imem_req,   0);
    chk("async_valid", bus.id_valid,   0);
    chk("async_count", bus.fifo_count, 0);
    chk("async_pc",    bus.id_pc,      0);
    chk("async_instr", bus.id_instr,   0);
    tick();
    tick();
    chk("hold_rst_count", bus.fifo_count, 0);

    // Backpressure from release: fetch 0..3 then stop
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req",  bus.imem_req,  1);
      chk("bp_addr", bus.imem_addr, i);
      tick();
    end
    chk("bp_stop_req", bus.imem_req, 0);
    tick();
    chk("bp_full_req",   bus.imem_req,   0);
    chk("bp_full_count", bus.fifo_count, 4);
    chk("bp_valid",      bus.id_valid,   1);
    chk("bp_pc",         bus.id_pc,      0);
    chk("bp_instr",      bus.id_instr,   16'h1000);
    tick();
    chk("bp_hold_req",   bus.imem_req,   0);
    chk("bp_hold_count", bus.fifo_count, 4);
    chk("bp_hold_pc",    bus.id_pc,      0);
    chk("bp_hold_instr", bus.id_instr,   16'h1000);
    bus.id_ready = 1'b1;
    #1;
    chk("bp_ready_no_req", bus.imem_req, 0);
    tick();
    bus.id_ready = 1'b0;
    #1;
    chk("pop1_req",   bus.imem_req,   1);
    chk("pop1_addr",  bus.imem_addr,  4);
    chk("pop1_pc",    bus.id_pc,      1);
    chk("pop1_count", bus.fifo_count, 3);
    tick();
    chk("pre_redir_count", bus.fifo_count, 3);
    chk("pre_redir_req",   bus.imem_req,   0);

    // Redirect with count=3 and a fetch in flight
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    #1;
    chk("redir_req", bus.imem_req, 0);
    tick();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    #1;
    chk("redir_count", bus.fifo_count, 0);
    chk("redir_valid", bus.id_valid,   0);
    chk("redir_req1",  bus.imem_req,   1);
    chk("redir_addr",  bus.imem_addr,  16'h0040);
    tick();
    chk("redir_e1_valid", bus.id_valid,  0);
    chk("redir_e1_addr",  bus.imem_addr, 16'h0041);
    tick();
    chk("redir_tgt_valid", bus.id_valid,   1);
    chk("redir_tgt_pc",    bus.id_pc,      16'h0040);
    chk("redir_tgt_instr", bus.id_instr,   16'h1040);
    chk("redir_tgt_count", bus.fifo_count, 1);

    // Fill to full, then drain with id_ready=1 checking strict ordering
    exp_pc = 16'h0040;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("fill_valid", bus.id_valid, 1);
      chk("fill_pc",    bus.id_pc,    exp_pc);
      chk("fill_le4",   (bus.fifo_count <= 3'd4), 1);
    end
    chk("fill_count", bus.fifo_count, 4);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exp_instr = exp_pc + 16'h1000;
      chk("drain_valid", bus.id_valid, 1);
      chk("drain_pc",    bus.id_pc,    exp_pc);
      chk("drain_instr", bus.id_instr, exp_instr);
      chk("drain_le4",   (bus.fifo_count <= 3'd4), 1);
      tick();
      exp_pc = exp_pc + 16'h0001;
    end
    chk("steady_req", bus.imem_req, 1);

    // Redirect near the top of the address space: wrap-around
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'hFFFE;
    #1;
    chk("wrap_redir_req", bus.imem_req, 0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("wrap_count", bus.fifo_count, 0);
    chk("wrap_valid", bus.id_valid,   0);
    chk("wrap_req",   bus.imem_req,   1);
    chk("wrap_addr0", bus.imem_addr,  16'hFFFE);
    tick();
    chk("wrap_e1_valid", bus.id_valid,  0);
    chk("wrap_addr1",    bus.imem_addr, 16'hFFFF);
    tick();
    chk("wrap_addr2", bus.imem_addr, 16'h0000);
    exp_pc = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      exp_instr = exp_pc + 16'h1000;
      chk("wrap_valid_seq", bus.id_valid, 1);
      chk("wrap_pc_seq",    bus.id_pc,    exp_pc);
      chk("wrap_instr_seq", bus.id_instr, exp_instr);
      tick();
      exp_pc = exp_pc + 16'h0001;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
